// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the fetch stage: EX-stage next-PC select codes and the
// fetch request FSM states.
package pc_fetch_unit_pkg;

  localparam int PC_SRC_BITS_COUNT = 2;
  localparam logic [PC_SRC_BITS_COUNT-1:0] PC_SRC_PC_PLUS_4    = 2'd0;
  localparam logic [PC_SRC_BITS_COUNT-1:0] PC_SRC_PC_PLUS_IMM  = 2'd1;
  localparam logic [PC_SRC_BITS_COUNT-1:0] PC_SRC_GPR_PLUS_IMM = 2'd2;

  localparam int FETCH_STATE_BITS_COUNT = 2;
  typedef enum logic [FETCH_STATE_BITS_COUNT-1:0] {
    FETCH_STATE_REQ  = 2'd0,
    FETCH_STATE_WAIT = 2'd1,
    FETCH_STATE_DROP = 2'd2
  } fetch_state_e;

  function automatic logic low_bits_set(input logic [1:0] low);
    return low != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_branch_target_unit.sv
// Resolves the redirect target from the EX-stage operands and flags targets
// that are not 4-byte aligned.
module branch_target_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [PC_SRC_BITS_COUNT-1:0] pc_source,
  input  logic [XLEN-1:0]              pc_ex,
  input  logic [XLEN-1:0]              imm_ex,
  input  logic [XLEN-1:0]              gpr_ex,
  output logic [XLEN-1:0]              target,
  output logic                         target_misalign
);

  logic [XLEN-1:0] pc_sum;
  logic [XLEN-1:0] gpr_sum;

  assign pc_sum  = pc_ex + imm_ex;
  assign gpr_sum = gpr_ex + imm_ex;

  always_comb begin
    target          = pc_ex + XLEN'(4);
    target_misalign = 1'b0;
    case (pc_source)
      PC_SRC_PC_PLUS_IMM: begin
        target          = pc_sum;
        target_misalign = low_bits_set(pc_sum[1:0]);
      end
      PC_SRC_GPR_PLUS_IMM: begin
        // Register-indirect jumps ignore bit 0 of the sum.
        target          = {gpr_sum[XLEN-1:1], 1'b0};
        target_misalign = low_bits_set({gpr_sum[1], 1'b0});
      end
      default: begin
        target          = pc_ex + XLEN'(4);
        target_misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns pc_f, drives the instruction-memory request handshake,
// loads IF/ID and discards wrong-path work on an EX redirect.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              stall_f,
  input  logic [PC_SRC_BITS_COUNT-1:0]      pc_source,
  input  logic                              branch_taken,
  input  logic [XLEN-1:0]                   pc_ex,
  input  logic [XLEN-1:0]                   imm_ex,
  input  logic [XLEN-1:0]                   gpr_ex,
  output logic                              imem_req_valid,
  output logic [XLEN-1:0]                   imem_req_addr,
  input  logic                              imem_req_ready,
  input  logic                              imem_rsp_valid,
  input  logic [31:0]                       imem_rsp_instr,
  output logic                              if_id_valid,
  output logic [XLEN-1:0]                   if_id_pc,
  output logic [31:0]                       if_id_instr,
  output logic                              flush_d,
  output logic                              flush_e,
  output logic                              target_misalign,
  output logic [FETCH_STATE_BITS_COUNT-1:0] fetch_state
);

  // Handshake: a request transfers on a cycle where imem_req_valid & imem_req_ready;
  // the address is held stable until then except when a redirect replaces it.
  // A response is a single-cycle imem_rsp_valid strobe with no back-pressure.

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] target;
  logic            target_misalign_raw;
  logic            hold_valid;
  logic [XLEN-1:0] hold_pc;
  logic [31:0]     hold_instr;
  logic            accept;
  logic            deliver;
  logic [XLEN-1:0] rsp_pc;

  branch_target_unit #(.XLEN(XLEN)) u_branch_target (
    .pc_source       (pc_source),
    .pc_ex           (pc_ex),
    .imm_ex          (imm_ex),
    .gpr_ex          (gpr_ex),
    .target          (target),
    .target_misalign (target_misalign_raw)
  );

  assign flush_d         = branch_taken;
  assign flush_e         = branch_taken;
  assign target_misalign = branch_taken & target_misalign_raw;
  assign imem_req_addr   = pc_f;
  assign fetch_state     = state;
  assign accept          = imem_req_valid & imem_req_ready;
  // pc_f already advanced past the outstanding request when it was accepted.
  assign rsp_pc          = pc_f - XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH_STATE_REQ;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH_STATE_REQ: begin
        if (accept) state_next = branch_taken ? FETCH_STATE_DROP : FETCH_STATE_WAIT;
      end
      FETCH_STATE_WAIT: begin
        if (imem_rsp_valid)    state_next = FETCH_STATE_REQ;
        else if (branch_taken) state_next = FETCH_STATE_DROP;
      end
      FETCH_STATE_DROP: begin
        if (imem_rsp_valid) state_next = FETCH_STATE_REQ;
      end
      default: state_next = FETCH_STATE_REQ;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    deliver        = 1'b0;
    case (state)
      FETCH_STATE_REQ:  imem_req_valid = rst_n & ~stall_f & ~hold_valid;
      FETCH_STATE_WAIT: deliver        = imem_rsp_valid & ~branch_taken;
      default: begin
        imem_req_valid = 1'b0;
        deliver        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pc_f <= RESET_PC;
    else if (branch_taken) pc_f <= target;
    else if (accept)       pc_f <= pc_f + XLEN'(4);
  end

  // Redirect beats stall; a response arriving under stall parks in the hold buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= '0;
      hold_valid  <= 1'b0;
      hold_pc     <= '0;
      hold_instr  <= '0;
    end else if (branch_taken) begin
      if_id_valid <= 1'b0;
      hold_valid  <= 1'b0;
    end else if (!stall_f) begin
      if (hold_valid) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= hold_pc;
        if_id_instr <= hold_instr;
        hold_valid  <= 1'b0;
      end else if (deliver) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= rsp_pc;
        if_id_instr <= imem_rsp_instr;
      end else begin
        if_id_valid <= 1'b0;
      end
    end else if (deliver) begin
      hold_valid <= 1'b1;
      hold_pc    <= rsp_pc;
      hold_instr <= imem_rsp_instr;
    end
  end

endmodule
